l2_request_arbiter: RTL and testbench

- Shares the single L2 cache port between NUM_L1 L1 data caches (one per core) in the multi-core integration.
- Sits between the L1 miss/writeback interfaces and the L2 L1-side interface (L1_read_request / L1_write_request / L1_word_address / L1_wdata).
- Latches one requester's transaction, drives it to L2 until L2 signals completion, then returns read data and a done pulse to that requester.
- Round-robin fairness among requesters.

---
 rtl/cache_pkg.sv | 18 +
 rtl/l2_request_arbiter_rr_select.sv | 33 +++
 rtl/l2_request_arbiter.sv | 135 +++++++++++++
 tb/tb_l2_request_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the L2 request arbiter: FSM states, L2 op encoding, default widths.
// No logic; imported by the arbiter and its round-robin picker.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } l2_op_t;

    localparam int DEFAULT_AW = 30;

endpackage

// File: rtl/l2_request_arbiter_rr_select.sv
// Combinational round-robin picker: first pending index at or above i_ptr, wrapping.
// Zero latency; o_vld is low when nothing is pending.
module rr_select
    import cache_pkg::*;
#(
    parameter int NUM = 2,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] i_pending,
    input  logic [IW-1:0]  i_ptr,
    output logic [NUM-1:0] o_onehot,
    output logic [IW-1:0]  o_idx,
    output logic           o_vld
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_j      = '0;
        for (int k = 0; k < NUM; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NUM);
            if (!o_vld && i_pending[w_j]) begin
                o_vld         = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares one L2 port among NUM_L1 L1 caches, one transaction at a time, round-robin.
// Grant one cycle after request; L2 request held until L2_done; done pulses the cycle after.
module l2_request_arbiter
    import cache_pkg::*;
#(
    parameter int n      = 32,
    parameter int NUM_L1 = 2,
    parameter int AW     = DEFAULT_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_L1-1:0]    req_read,
    input  logic [NUM_L1-1:0]    req_write,
    input  logic [NUM_L1*AW-1:0] req_addr,
    input  logic [NUM_L1*n-1:0]  req_wdata,
    output logic [NUM_L1-1:0]    grant,
    output logic [NUM_L1-1:0]    done,
    output logic [n-1:0]         rdata,
    output logic                 L1_read_request,
    output logic                 L1_write_request,
    output logic [AW-1:0]        L1_word_address,
    output logic [n-1:0]         L1_wdata,
    input  logic                 L2_done,
    input  logic [n-1:0]         L2_rdata
);

    localparam int IW = $clog2(NUM_L1);

    arb_state_t        r_state;
    l2_op_t            r_op;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    logic [NUM_L1-1:0] r_grant;
    logic [NUM_L1-1:0] r_done;
    logic [n-1:0]      r_rdata;
    logic              r_rd_req;
    logic              r_wr_req;
    logic [AW-1:0]     r_addr;
    logic [n-1:0]      r_wdata;

    logic [NUM_L1-1:0] w_pending;
    logic [NUM_L1-1:0] w_onehot;
    logic [IW-1:0]     w_idx;
    logic              w_vld;
    logic [AW-1:0]     w_sel_addr;
    logic [n-1:0]      w_sel_wdata;
    logic              w_sel_write;

    assign w_pending   = req_read | req_write;
    // Read and write together on one requester resolves to a write.
    assign w_sel_write = |(w_onehot & req_write);

    rr_select #(.NUM(NUM_L1), .IW(IW)) u_rr_select (
        .i_pending (w_pending),
        .i_ptr     (r_ptr),
        .o_onehot  (w_onehot),
        .o_idx     (w_idx),
        .o_vld     (w_vld)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_L1; i++) begin
            if (w_onehot[i]) begin
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*n +: n];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= OP_READ;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_vld) begin
                        r_grant  <= w_onehot;
                        r_owner  <= w_idx;
                        r_op     <= w_sel_write ? OP_WRITE : OP_READ;
                        r_rd_req <= !w_sel_write;
                        r_wr_req <= w_sel_write;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_state  <= BUSY;
                    end else begin
                        r_grant <= '0;
                    end
                end
                BUSY: begin
                    // Requester inputs are deliberately not looked at here.
                    if (L2_done) begin
                        r_rd_req <= 1'b0;
                        r_wr_req <= 1'b0;
                        if (r_op == OP_READ) begin
                            r_rdata <= L2_rdata;
                        end
                        r_done  <= r_grant;
                        r_ptr   <= (r_owner == IW'(NUM_L1 - 1)) ? '0 : r_owner + 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant            = r_grant;
    assign done             = r_done;
    assign rdata            = r_rdata;
    assign L1_read_request  = r_rd_req;
    assign L1_write_request = r_wr_req;
    assign L1_word_address  = r_addr;
    assign L1_wdata         = r_wdata;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter (NUM_L1=2): hand-computed expectations per cycle.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_l2_request_arbiter;

    localparam int N  = 32;
    localparam int NL = 2;
    localparam int AW = 30;

    logic             clk = 1'b0;
    logic             reset;
    logic [NL-1:0]    req_read;
    logic [NL-1:0]    req_write;
    logic [NL*AW-1:0] req_addr;
    logic [NL*N-1:0]  req_wdata;
    logic [NL-1:0]    grant;
    logic [NL-1:0]    done;
    logic [N-1:0]     rdata;
    logic             L1_read_request;
    logic             L1_write_request;
    logic [AW-1:0]    L1_word_address;
    logic [N-1:0]     L1_wdata;
    logic             L2_done;
    logic [N-1:0]     L2_rdata;

    int vectors = 0;
    int miscompares = 0;

    l2_request_arbiter #(.n(N), .NUM_L1(NL), .AW(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .grant            (grant),
        .done             (done),
        .rdata            (rdata),
        .L1_read_request  (L1_read_request),
        .L1_write_request (L1_write_request),
        .L1_word_address  (L1_word_address),
        .L1_wdata         (L1_wdata),
        .L2_done          (L2_done),
        .L2_rdata         (L2_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the whole control picture in one line per cycle.
    task automatic chk_ctl(input string tag, input logic [1:0] g, input logic [1:0] d,
                           input logic rd, input logic wr);
        chk({tag, ".grant"}, 64'(grant), 64'(g));
        chk({tag, ".done"},  64'(done),  64'(d));
        chk({tag, ".rdreq"}, 64'(L1_read_request),  64'(rd));
        chk({tag, ".wrreq"}, 64'(L1_write_request), 64'(wr));
    endtask

    initial begin
        reset = 1'b1; req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        L2_done = 1'b0; L2_rdata = '0;
        #1;
        chk_ctl("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("reset.addr",  64'(L1_word_address), 64'h0);
        chk("reset.wdata", 64'(L1_wdata), 64'h0);
        chk("reset.rdata", 64'(rdata), 64'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single read from L1 0, L2 answers on the 4th BUSY cycle.
        req_read = 2'b01; req_addr[0 +: AW] = 30'h40;
        tick();
        chk_ctl("rd.c1", 2'b01, 2'b00, 1'b1, 1'b0);
        chk("rd.addr", 64'(L1_word_address), 64'h40);
        tick(); chk_ctl("rd.c2", 2'b01, 2'b00, 1'b1, 1'b0);
        tick(); chk_ctl("rd.c3", 2'b01, 2'b00, 1'b1, 1'b0);
        tick(); chk_ctl("rd.c4", 2'b01, 2'b00, 1'b1, 1'b0);
        chk("rd.addr_held", 64'(L1_word_address), 64'h40);
        L2_done = 1'b1; L2_rdata = 32'hDEADBEEF;
        tick();
        L2_done = 1'b0; L2_rdata = '0;
        chk_ctl("rd.resp", 2'b01, 2'b01, 1'b0, 1'b0);
        chk("rd.rdata", 64'(rdata), 64'hDEADBEEF);
        req_read = 2'b00;
        tick(); chk_ctl("rd.idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Single write from L1 1; L2_rdata on a write must not reach rdata.
        req_write = 2'b10; req_addr[AW +: AW] = 30'h10; req_wdata[N +: N] = 32'h5;
        tick();
        chk_ctl("wr.c1", 2'b10, 2'b00, 1'b0, 1'b1);
        chk("wr.addr",  64'(L1_word_address), 64'h10);
        chk("wr.wdata", 64'(L1_wdata), 64'h5);
        L2_done = 1'b1; L2_rdata = 32'h12345678;
        tick();
        L2_done = 1'b0;
        chk_ctl("wr.resp", 2'b10, 2'b10, 1'b0, 1'b0);
        chk("wr.rdata_kept", 64'(rdata), 64'hDEADBEEF);
        req_write = 2'b00;
        tick(); chk_ctl("wr.idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Stray L2_done while idle is ignored.
        L2_done = 1'b1;
        tick();
        L2_done = 1'b0;
        chk_ctl("stray", 2'b00, 2'b00, 1'b0, 1'b0);

        // Simultaneous requests from reset: rotation 0,1,0.
        reset = 1'b1; #1; reset = 1'b0;
        req_read = 2'b11; req_addr[0 +: AW] = 30'h100; req_addr[AW +: AW] = 30'h200;
        tick();
        chk_ctl("sim.g0", 2'b01, 2'b00, 1'b1, 1'b0);
        chk("sim.addr0", 64'(L1_word_address), 64'h100);
        L2_done = 1'b1; L2_rdata = 32'h11110000;
        tick();
        L2_done = 1'b0;
        chk_ctl("sim.d0", 2'b01, 2'b01, 1'b0, 1'b0);
        req_read = 2'b10;
        tick();
        chk_ctl("sim.idle0", 2'b00, 2'b00, 1'b0, 1'b0);
        req_read = 2'b11;
        tick();
        chk_ctl("sim.g1", 2'b10, 2'b00, 1'b1, 1'b0);
        chk("sim.addr1", 64'(L1_word_address), 64'h200);
        L2_done = 1'b1; L2_rdata = 32'h22220000;
        tick();
        L2_done = 1'b0;
        chk_ctl("sim.d1", 2'b10, 2'b10, 1'b0, 1'b0);
        chk("sim.rdata1", 64'(rdata), 64'h22220000);
        req_read = 2'b01;
        tick(); chk_ctl("sim.idle1", 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk_ctl("sim.g0b", 2'b01, 2'b00, 1'b1, 1'b0);
        L2_done = 1'b1; L2_rdata = 32'h33330000;
        tick();
        L2_done = 1'b0;
        chk("sim.rdata0b", 64'(rdata), 64'h33330000);
        req_read = 2'b00;
        tick();

        // Read and write together on L1 0 resolve to a write.
        req_read = 2'b01; req_write = 2'b01; req_wdata[0 +: N] = 32'hA5A50001;
        tick();
        chk_ctl("rw.c1", 2'b01, 2'b00, 1'b0, 1'b1);
        chk("rw.wdata", 64'(L1_wdata), 64'hA5A50001);
        L2_done = 1'b1; L2_rdata = 32'hFFFF0000;
        tick();
        L2_done = 1'b0;
        chk_ctl("rw.resp", 2'b01, 2'b01, 1'b0, 1'b0);
        chk("rw.rdata_kept", 64'(rdata), 64'h33330000);
        req_read = 2'b00; req_write = 2'b00;
        tick();

        // Request dropped mid-BUSY still completes.
        req_read = 2'b01; req_addr[0 +: AW] = 30'h300;
        tick();
        chk_ctl("drop.c1", 2'b01, 2'b00, 1'b1, 1'b0);
        req_read = 2'b00;
        tick();
        chk_ctl("drop.c2", 2'b01, 2'b00, 1'b1, 1'b0);
        chk("drop.addr", 64'(L1_word_address), 64'h300);
        L2_done = 1'b1; L2_rdata = 32'hCAFEF00D;
        tick();
        L2_done = 1'b0;
        chk_ctl("drop.resp", 2'b01, 2'b01, 1'b0, 1'b0);
        chk("drop.rdata", 64'(rdata), 64'hCAFEF00D);
        tick();

        // Reset in BUSY: pointer is 1 here, L1 1 is granted, then reset clears everything.
        req_read = 2'b10; req_addr[AW +: AW] = 30'h3FF;
        tick();
        chk_ctl("rst.busy", 2'b10, 2'b00, 1'b1, 1'b0);
        reset = 1'b1; req_read = 2'b00;
        #1;
        chk_ctl("rst.async", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("rst.addr",  64'(L1_word_address), 64'h0);
        chk("rst.rdata", 64'(rdata), 64'h0);
        L2_done = 1'b1;
        tick();
        L2_done = 1'b0;
        chk_ctl("rst.nodone", 2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        // Both pending after reset: pointer back at 0 so L1 0 wins.
        req_read = 2'b11; req_addr[0 +: AW] = 30'h77;
        tick();
        chk_ctl("post.g", 2'b01, 2'b00, 1'b1, 1'b0);
        chk("post.addr", 64'(L1_word_address), 64'h77);
        L2_done = 1'b1; L2_rdata = 32'h0BADF00D;
        tick();
        L2_done = 1'b0;
        chk_ctl("post.resp", 2'b01, 2'b01, 1'b0, 1'b0);
        chk("post.rdata", 64'(rdata), 64'h0BADF00D);
        req_read = 2'b00;
        tick();
        chk_ctl("post.idle", 2'b00, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
